// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory request arbiter.
//   arb_state_t      : request-side FSM states (ARB_IDLE, ARB_WDATA)
//   CLIENT_IC/DC     : client IDs, also the MSB of the external memory tag
//   DEF_DATA_BEATS   : default write-data beats per write request
// Also supplies fallback widths for the MEM_* width macros when the
// build does not define them.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 8
`endif

package mem_arb_pkg;
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_WDATA = 1'b1
  } arb_state_t;

  localparam logic CLIENT_IC = 1'b0;
  localparam logic CLIENT_DC = 1'b1;

  localparam int unsigned DEF_DATA_BEATS = 4;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: two-input request picker for mem_req_arbiter.
//   clk, reset    : clock, synchronous active-low reset
//   en            : picking enabled (arbiter idle and out of reset)
//   ic/dc_valid   : client request valids
//   ready         : downstream request ready
//   grant_id      : winning client ID
//   grant_valid   : winner has a valid request while enabled
//   accept        : winner handshake completes this cycle
// Build option MEM_ARB_RR_EN: round-robin pointer; otherwise the dcache
// always wins contention and no pointer register exists.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic ic_valid,
  input  logic dc_valid,
  input  logic ready,
  output logic grant_id,
  output logic grant_valid,
  output logic accept
);

  logic locked_q;
  logic lock_id_q;
  logic favour;

`ifdef MEM_ARB_RR_EN
  logic ptr_q;

  // Priority flips to the client that was not just served.
  always_ff @(posedge clk) begin
    if (!reset)      ptr_q <= CLIENT_DC;
    else if (accept) ptr_q <= ~grant_id;
  end

  assign favour = ptr_q;
`else
  assign favour = CLIENT_DC;
`endif

  always_comb begin
    grant_id = favour;
    if (locked_q)                   grant_id = lock_id_q;
    else if (ic_valid && !dc_valid) grant_id = CLIENT_IC;
    else if (dc_valid && !ic_valid) grant_id = CLIENT_DC;
  end

  assign grant_valid = en & ((grant_id == CLIENT_IC) ? ic_valid : dc_valid);
  assign accept      = grant_valid & ready;

  // A presented but unaccepted request pins the winner so the outgoing
  // fields stay stable until its handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      locked_q  <= 1'b0;
      lock_id_q <= CLIENT_DC;
    end else if (grant_valid && !ready) begin
      locked_q  <= 1'b1;
      lock_id_q <= grant_id;
    end else begin
      locked_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: icache/dcache arbiter onto the single external memory
// channel. Requests and write data pass through combinationally; a write
// locks ownership for DATA_BEATS data beats. Responses are routed by the
// MSB of mem_resp_tag (0 = icache, 1 = dcache) with no backpressure.
//   clk, reset            : clock, synchronous active-low reset
//   ic_* / dc_*           : client request, write-data and response ports
//   mem_req_*             : external request and write-data ports
//   mem_resp_*            : external response inputs
// Build option MEM_ARB_RR_EN: round-robin arbitration (default: dcache
// fixed priority).
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = `MEM_ADDR_BITS,
  parameter int unsigned DATA_BITS  = `MEM_DATA_BITS,
  parameter int unsigned TAG_BITS   = `MEM_TAG_BITS,
  parameter int unsigned DATA_BEATS = DEF_DATA_BEATS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ic_req_valid,
  output logic                   ic_req_ready,
  input  logic                   ic_req_rw,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic [TAG_BITS-2:0]    ic_req_tag,
  input  logic                   ic_req_data_valid,
  output logic                   ic_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
  output logic                   ic_resp_valid,
  output logic [TAG_BITS-2:0]    ic_resp_tag,
  output logic [DATA_BITS-1:0]   ic_resp_data,
  input  logic                   dc_req_valid,
  output logic                   dc_req_ready,
  input  logic                   dc_req_rw,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic [TAG_BITS-2:0]    dc_req_tag,
  input  logic                   dc_req_data_valid,
  output logic                   dc_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                   dc_resp_valid,
  output logic [TAG_BITS-2:0]    dc_resp_tag,
  output logic [DATA_BITS-1:0]   dc_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_rw,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic [TAG_BITS-1:0]    mem_req_tag,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [TAG_BITS-1:0]    mem_resp_tag,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int unsigned CNT_W = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_BEATS - 1);

  arb_state_t       state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic run;
  logic idle;
  logic grant_id;
  logic grant_valid;
  logic accept;
  logic beat_fire;

  // Reset is applied to the outputs as well so nothing handshakes while low.
  assign run  = reset;
  assign idle = (state_q == ARB_IDLE);

  mem_arb_pick u_pick (
    .clk        (clk),
    .reset      (reset),
    .en         (run & idle),
    .ic_valid   (ic_req_valid),
    .dc_valid   (dc_req_valid),
    .ready      (mem_req_ready),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .accept     (accept)
  );

  // Request channel
  assign mem_req_valid = grant_valid;
  assign mem_req_rw    = (grant_id == CLIENT_IC) ? ic_req_rw   : dc_req_rw;
  assign mem_req_addr  = (grant_id == CLIENT_IC) ? ic_req_addr : dc_req_addr;
  assign mem_req_tag   = {grant_id, (grant_id == CLIENT_IC) ? ic_req_tag : dc_req_tag};
  assign ic_req_ready  = run & idle & (grant_id == CLIENT_IC) & mem_req_ready;
  assign dc_req_ready  = run & idle & (grant_id == CLIENT_DC) & mem_req_ready;

  // Write-data channel
  assign mem_req_data_valid = run & !idle &
                              ((owner_q == CLIENT_IC) ? ic_req_data_valid : dc_req_data_valid);
  assign mem_req_data_bits  = (owner_q == CLIENT_IC) ? ic_req_data_bits : dc_req_data_bits;
  assign mem_req_data_mask  = (owner_q == CLIENT_IC) ? ic_req_data_mask : dc_req_data_mask;
  assign ic_req_data_ready  = run & !idle & (owner_q == CLIENT_IC) & mem_req_data_ready;
  assign dc_req_data_ready  = run & !idle & (owner_q == CLIENT_DC) & mem_req_data_ready;
  assign beat_fire          = mem_req_data_valid & mem_req_data_ready;

  // Response routing
  assign ic_resp_valid = run & mem_resp_valid & !mem_resp_tag[TAG_BITS-1];
  assign dc_resp_valid = run & mem_resp_valid &  mem_resp_tag[TAG_BITS-1];
  assign ic_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
  assign dc_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (accept && mem_req_rw) begin
          state_d    = ARB_WDATA;
          owner_d    = grant_id;
          beat_cnt_d = '0;
        end
      end
      ARB_WDATA: begin
        if (beat_fire) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = ARB_IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      owner_q    <= CLIENT_DC;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
